// File: rtl/fdtd_pkg.sv
// Shared types and constants for the FDTD time-step scheduler.
package fdtd_pkg;

   // Scheduler FSM states
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HY_ISSUE,
      ST_HY_WAIT,
      ST_EZ_ISSUE,
      ST_EZ_WAIT,
      ST_SRC_ISSUE,
      ST_SRC_WAIT,
      ST_STEP_CHK,
      ST_DONE
   } sched_state_e;

   // Phase codes reported to the host
   localparam logic [1:0] PH_IDLE = 2'd0;
   localparam logic [1:0] PH_HY   = 2'd1;
   localparam logic [1:0] PH_EZ   = 2'd2;
   localparam logic [1:0] PH_SRC  = 2'd3;

   // Default watchdog limit, in cycles spent in one WAIT state
   localparam int DEF_WDOG_CYCLES = 1023;

   // Map a state onto the phase it belongs to (ISSUE and WAIT share a phase)
   function automatic logic [1:0] phase_of(input sched_state_e s);
      logic [1:0] ph;
      case (s)
         ST_HY_ISSUE, ST_HY_WAIT:   ph = PH_HY;
         ST_EZ_ISSUE, ST_EZ_WAIT:   ph = PH_EZ;
         ST_SRC_ISSUE, ST_SRC_WAIT: ph = PH_SRC;
         default:                   ph = PH_IDLE;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/fdtd_step_sched_wdog.sv
// Watchdog counter: cleared while disabled, counts while enabled, flags expiry.
module fdtd_wdog
   import fdtd_pkg::*;
#(
   parameter int WDOG_W      = 16,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   // Expiry is flagged while the count sits one below the limit, so the
   // edge that would take it to WDOG_CYCLES is the edge that acts on it.
   localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_CYCLES - 1);

   logic [WDOG_W-1:0] cnt_q;
   logic [WDOG_W-1:0] cnt_d;

   // Next count: clear has priority, saturate at the limit
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/fdtd_step_sched.sv
// Time-step scheduler: sequences Hy, Ez and optional source phases per step,
// waiting on memory write-back between phases, for a programmed step count.
module fdtd_step_sched
   import fdtd_pkg::*;
#(
   parameter int STEP_W      = 16,
   parameter int WDOG_W      = 16,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [STEP_W-1:0] time_steps_i,
   input  logic              src_en_i,
   input  logic              hy_wb_done_i,
   input  logic              ez_wb_done_i,
   input  logic              src_wb_done_i,
   output logic              calc_Hy_flg_o,
   output logic              calc_Ez_flg_o,
   output logic              calc_src_flg_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [STEP_W-1:0] step_cnt_o,
   output logic [1:0]        phase_o
);

   sched_state_e      state_q, state_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic              src_en_q, src_en_d;
   logic              error_q, error_d;
   logic              hy_flg_q, ez_flg_q, src_flg_q;
   logic              busy_q, done_q;
   logic [1:0]        phase_q;

   logic              in_wait;
   logic              wdog_expire;

   assign in_wait = (state_q == ST_HY_WAIT) || (state_q == ST_EZ_WAIT) ||
                    (state_q == ST_SRC_WAIT);

   // The watchdog is held clear outside WAIT, so each WAIT entry starts at 0
   fdtd_wdog #(
      .WDOG_W      (WDOG_W),
      .WDOG_CYCLES (WDOG_CYCLES)
   ) u_wdog (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .clr_i    (!in_wait),
      .en_i     (in_wait),
      .expire_o (wdog_expire)
   );

   // Next-state and datapath updates; abort overrides everything else
   always_comb begin
      state_d    = state_q;
      steps_d    = steps_q;
      step_cnt_d = step_cnt_q;
      src_en_d   = src_en_q;
      error_d    = error_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               steps_d    = time_steps_i;
               src_en_d   = src_en_i;
               step_cnt_d = '0;
               error_d    = 1'b0;
               state_d    = ST_STEP_CHK;
            end
         end
         ST_HY_ISSUE:  state_d = ST_HY_WAIT;
         ST_HY_WAIT: begin
            if (hy_wb_done_i) begin
               state_d = ST_EZ_ISSUE;
            end else if (wdog_expire) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_EZ_ISSUE:  state_d = ST_EZ_WAIT;
         ST_EZ_WAIT: begin
            if (ez_wb_done_i) begin
               if (src_en_q) begin
                  state_d = ST_SRC_ISSUE;
               end else begin
                  step_cnt_d = step_cnt_q + 1'b1;
                  state_d    = ST_STEP_CHK;
               end
            end else if (wdog_expire) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_SRC_ISSUE: state_d = ST_SRC_WAIT;
         ST_SRC_WAIT: begin
            if (src_wb_done_i) begin
               step_cnt_d = step_cnt_q + 1'b1;
               state_d    = ST_STEP_CHK;
            end else if (wdog_expire) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_STEP_CHK: begin
            state_d = (step_cnt_q == steps_q) ? ST_DONE : ST_HY_ISSUE;
         end
         ST_DONE:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
      if (abort_i && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         step_cnt_d = step_cnt_q;
         error_d    = error_q;
      end
   end

   // State and registered Moore outputs, decoded from the next state so they
   // line up with the state they belong to
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         steps_q    <= '0;
         step_cnt_q <= '0;
         src_en_q   <= 1'b0;
         error_q    <= 1'b0;
         hy_flg_q   <= 1'b0;
         ez_flg_q   <= 1'b0;
         src_flg_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         phase_q    <= PH_IDLE;
      end else begin
         state_q    <= state_d;
         steps_q    <= steps_d;
         step_cnt_q <= step_cnt_d;
         src_en_q   <= src_en_d;
         error_q    <= error_d;
         hy_flg_q   <= (state_d == ST_HY_ISSUE);
         ez_flg_q   <= (state_d == ST_EZ_ISSUE);
         src_flg_q  <= (state_d == ST_SRC_ISSUE);
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_d == ST_DONE);
         phase_q    <= phase_of(state_d);
      end
   end

   assign calc_Hy_flg_o  = hy_flg_q;
   assign calc_Ez_flg_o  = ez_flg_q;
   assign calc_src_flg_o = src_flg_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign step_cnt_o     = step_cnt_q;
   assign phase_o        = phase_q;

endmodule

// File: tb/tb_fdtd_step_sched.sv
// Directed self-checking bench for fdtd_step_sched.
module tb_fdtd_step_sched;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [15:0] time_steps_i = '0;
   logic        src_en_i = 1'b0;
   logic        hy_wb_done_i = 1'b0;
   logic        ez_wb_done_i = 1'b0;
   logic        src_wb_done_i = 1'b0;
   logic        calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o;
   logic        busy_o, done_o, error_o;
   logic [15:0] step_cnt_o;
   logic [1:0]  phase_o;

   int tests = 0;
   int fails = 0;
   int seq[$];
   int done_seen = 0;

   fdtd_step_sched #(
      .STEP_W      (16),
      .WDOG_W      (16),
      .WDOG_CYCLES (8)
   ) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .time_steps_i   (time_steps_i),
      .src_en_i       (src_en_i),
      .hy_wb_done_i   (hy_wb_done_i),
      .ez_wb_done_i   (ez_wb_done_i),
      .src_wb_done_i  (src_wb_done_i),
      .calc_Hy_flg_o  (calc_Hy_flg_o),
      .calc_Ez_flg_o  (calc_Ez_flg_o),
      .calc_src_flg_o (calc_src_flg_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .error_o        (error_o),
      .step_cnt_o     (step_cnt_o),
      .phase_o        (phase_o)
   );

   always #5 CLK = ~CLK;

   // Advance one clock and record flags (1=Hy, 2=Ez, 3=src) and done pulses
   task automatic tick();
      @(posedge CLK);
      #1;
      if (calc_Hy_flg_o)  seq.push_back(1);
      if (calc_Ez_flg_o)  seq.push_back(2);
      if (calc_src_flg_o) seq.push_back(3);
      if (done_o)         done_seen++;
   endtask

   task automatic clr_mon();
      seq.delete();
      done_seen = 0;
   endtask

   task automatic start_run(input int steps, input bit src);
      time_steps_i = 16'(steps);
      src_en_i     = src;
      start_i      = 1'b1;
      tick();
      start_i      = 1'b0;
   endtask

   // Wait (bounded) until the given flag is high in the current cycle
   task automatic wait_flag(input int which, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if ((which == 1 && calc_Hy_flg_o) || (which == 2 && calc_Ez_flg_o) ||
             (which == 3 && calc_src_flg_o))
            found = 1'b1;
         else
            tick();
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL %s: flag %0d not seen, got none within 40 cycles", name, which);
      end
   endtask

   // Responder: return each done 5 cycles after its flag until busy drops
   task automatic run_auto(input string name);
      int hc = 0, ec = 0, sc = 0;
      bit fin = 1'b0;
      for (int i = 0; i < 300 && !fin; i++) begin
         tick();
         hy_wb_done_i = 1'b0; ez_wb_done_i = 1'b0; src_wb_done_i = 1'b0;
         if (hc > 0) begin hc--; if (hc == 0) hy_wb_done_i = 1'b1; end
         if (ec > 0) begin ec--; if (ec == 0) ez_wb_done_i = 1'b1; end
         if (sc > 0) begin sc--; if (sc == 0) src_wb_done_i = 1'b1; end
         if (calc_Hy_flg_o)  hc = 4;
         if (calc_Ez_flg_o)  ec = 4;
         if (calc_src_flg_o) sc = 4;
         if (!busy_o) fin = 1'b1;
      end
      hy_wb_done_i = 1'b0; ez_wb_done_i = 1'b0; src_wb_done_i = 1'b0;
      tests++;
      if (!fin) begin
         fails++;
         $display("FAIL %s timeout: busy_o got 1 required 0 within 300 cycles", name);
      end
   endtask

   task automatic test_reset();
      logic [23:0] outs;
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      outs = {calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o, busy_o, done_o,
              error_o, step_cnt_o, phase_o};
      tests++;
      if (outs !== 24'h0) begin
         fails++;
         $display("FAIL reset outputs: got %h required 000000", outs);
      end
      RST_N = 1'b1;
      tick();
   endtask

   // Full run with auto responder; checks flag order, done count, step count
   task automatic test_multi_step(input int steps, input bit src, input string name);
      int exp_seq[$];
      int bad = -1;
      int src_cnt = 0;
      clr_mon();
      start_run(steps, src);
      run_auto(name);
      for (int s = 0; s < steps; s++) begin
         exp_seq.push_back(1);
         exp_seq.push_back(2);
         if (src) exp_seq.push_back(3);
      end
      tests++;
      if (seq.size() != exp_seq.size()) begin
         fails++;
         $display("FAIL %s flag count: got %0d required %0d", name, seq.size(), exp_seq.size());
      end else begin
         for (int i = 0; i < seq.size(); i++)
            if (bad < 0 && seq[i] != exp_seq[i]) bad = i;
         if (bad >= 0) begin
            fails++;
            $display("FAIL %s flag order at %0d: got %0d required %0d", name, bad, seq[bad], exp_seq[bad]);
         end
      end
      foreach (seq[i]) if (seq[i] == 3) src_cnt++;
      tests++;
      if (src_cnt != (src ? steps : 0)) begin
         fails++;
         $display("FAIL %s src flags: got %0d required %0d", name, src_cnt, src ? steps : 0);
      end
      tests++;
      if (done_seen != 1) begin
         fails++;
         $display("FAIL %s done pulses: got %0d required 1", name, done_seen);
      end
      tests++;
      if (step_cnt_o !== 16'(steps)) begin
         fails++;
         $display("FAIL %s step_cnt: got %0d required %0d", name, step_cnt_o, steps);
      end
      tests++;
      if (error_o !== 1'b0) begin
         fails++;
         $display("FAIL %s error: got %b required 0", name, error_o);
      end
   endtask

   task automatic test_zero_steps();
      clr_mon();
      start_run(0, 1'b1);
      tests++;
      if (done_o !== 1'b0 || busy_o !== 1'b1) begin
         fails++;
         $display("FAIL zero step_chk: got done=%b busy=%b required done=0 busy=1", done_o, busy_o);
      end
      tick();
      tests++;
      if (done_o !== 1'b1) begin
         fails++;
         $display("FAIL zero done timing: got %b required 1", done_o);
      end
      tick();
      tests++;
      if (busy_o !== 1'b0 || done_seen != 1 || seq.size() != 0 || step_cnt_o !== 16'd0) begin
         fails++;
         $display("FAIL zero end: got busy=%b dones=%0d flags=%0d cnt=%0d required 0 1 0 0",
                  busy_o, done_seen, seq.size(), step_cnt_o);
      end
   endtask

   task automatic test_watchdog();
      clr_mon();
      start_run(1, 1'b0);
      wait_flag(1, "wdog hy");
      tick();
      hy_wb_done_i = 1'b1;
      tick();
      hy_wb_done_i = 1'b0;
      wait_flag(2, "wdog ez");
      repeat (8) tick();
      tests++;
      if (error_o !== 1'b0 || busy_o !== 1'b1) begin
         fails++;
         $display("FAIL wdog early: got error=%b busy=%b required 0 1", error_o, busy_o);
      end
      tick();
      tests++;
      if (error_o !== 1'b1 || busy_o !== 1'b0) begin
         fails++;
         $display("FAIL wdog expiry: got error=%b busy=%b required 1 0", error_o, busy_o);
      end
      tests++;
      if (done_seen != 0) begin
         fails++;
         $display("FAIL wdog done: got %0d required 0", done_seen);
      end
      start_run(0, 1'b0);
      tests++;
      if (error_o !== 1'b0) begin
         fails++;
         $display("FAIL wdog clear on start: got %b required 0", error_o);
      end
      repeat (2) tick();
   endtask

   task automatic test_abort();
      int nflags;
      clr_mon();
      start_run(3, 1'b0);
      for (int s = 0; s < 2; s++) begin
         wait_flag(1, "abort hy");
         tick();
         hy_wb_done_i = 1'b1;
         tick();
         hy_wb_done_i = 1'b0;
         wait_flag(2, "abort ez");
         if (s == 0) begin
            tick();
            ez_wb_done_i = 1'b1;
            tick();
            ez_wb_done_i = 1'b0;
         end
      end
      tick();
      abort_i = 1'b1;
      ez_wb_done_i = 1'b1;
      tick();
      abort_i = 1'b0;
      ez_wb_done_i = 1'b0;
      tests++;
      if (busy_o !== 1'b0 || step_cnt_o !== 16'd1 || phase_o !== 2'd0) begin
         fails++;
         $display("FAIL abort: got busy=%b cnt=%0d phase=%0d required 0 1 0", busy_o, step_cnt_o, phase_o);
      end
      nflags = seq.size();
      ez_wb_done_i = 1'b1;
      tick();
      ez_wb_done_i = 1'b0;
      repeat (5) tick();
      tests++;
      if (seq.size() != nflags || done_seen != 0 || busy_o !== 1'b0 || step_cnt_o !== 16'd1) begin
         fails++;
         $display("FAIL abort late done: got flags=%0d dones=%0d busy=%b cnt=%0d required %0d 0 0 1",
                  seq.size(), done_seen, busy_o, step_cnt_o, nflags);
      end
   endtask

   task automatic test_ignored_and_reset();
      logic [23:0] outs;
      clr_mon();
      start_run(2, 1'b0);
      wait_flag(1, "ign hy");
      tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tests++;
      if (busy_o !== 1'b1 || phase_o !== 2'd1 || calc_Hy_flg_o !== 1'b0) begin
         fails++;
         $display("FAIL start in hy_wait: got busy=%b phase=%0d hy=%b required 1 1 0", busy_o, phase_o, calc_Hy_flg_o);
      end
      hy_wb_done_i = 1'b1;
      tick();
      hy_wb_done_i = 1'b0;
      wait_flag(2, "ign ez");
      tick();
      hy_wb_done_i = 1'b1;
      src_wb_done_i = 1'b1;
      tick();
      hy_wb_done_i = 1'b0;
      src_wb_done_i = 1'b0;
      tests++;
      if (phase_o !== 2'd2 || calc_Hy_flg_o !== 1'b0 || calc_src_flg_o !== 1'b0 || step_cnt_o !== 16'd0) begin
         fails++;
         $display("FAIL spurious done in ez_wait: got phase=%0d hy=%b src=%b cnt=%0d required 2 0 0 0",
                  phase_o, calc_Hy_flg_o, calc_src_flg_o, step_cnt_o);
      end
      ez_wb_done_i = 1'b1;
      tick();
      ez_wb_done_i = 1'b0;
      wait_flag(1, "ign step1 hy");
      tests++;
      if (step_cnt_o !== 16'd1 || busy_o !== 1'b1) begin
         fails++;
         $display("FAIL before reset: got cnt=%0d busy=%b required 1 1", step_cnt_o, busy_o);
      end
      RST_N = 1'b0;
      #1;
      outs = {calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o, busy_o, done_o,
              error_o, step_cnt_o, phase_o};
      tests++;
      if (outs !== 24'h0) begin
         fails++;
         $display("FAIL async reset: got %h required 000000", outs);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      tests++;
      if (busy_o !== 1'b0) begin
         fails++;
         $display("FAIL after reset: busy got %b required 0", busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_multi_step(3, 1'b1, "src_run");
      test_zero_steps();
      test_multi_step(2, 1'b0, "no_src");
      test_watchdog();
      test_abort();
      test_ignored_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation got 200000 ns required completion earlier");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fdtd_step_sched.md
# fdtd_step_sched

Time-step scheduler for the FDTD accelerator. It sits above `fdtd_calc_ctrl` and drives that controller's `calc_Hy_flg_i`, `calc_Ez_flg_i` and `calc_src_flg_i` inputs. For each time step it runs the Hy update, then the Ez update, then (optionally) the source injection. Before issuing each next phase it waits for the memory controller to report write-back complete, repeats for a programmed number of steps, and reports done or error to the host register file.

## Interface
Parameters:
- `STEP_W`, 16: width of the step count and step counter.
- `WDOG_W`, 16: width of the watchdog counter.
- `WDOG_CYCLES`, 1023: maximum cycles allowed in any WAIT state before an error is raised.

Ports:
- `CLK`, in, 1: clock.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: run request, sampled only in IDLE.
- `abort_i`, in, 1: cancels a run in progress.
- `time_steps_i`, in, STEP_W: number of steps, latched on an accepted start.
- `src_en_i`, in, 1: source phase enable, latched on an accepted start.
- `hy_wb_done_i`, in, 1: Hy write-back complete pulse from the memory controller.
- `ez_wb_done_i`, in, 1: Ez write-back complete pulse from the memory controller.
- `src_wb_done_i`, in, 1: source write-back complete pulse from the memory controller.
- `calc_Hy_flg_o`, out, 1: one-cycle Hy phase request to `fdtd_calc_ctrl`.
- `calc_Ez_flg_o`, out, 1: one-cycle Ez phase request.
- `calc_src_flg_o`, out, 1: one-cycle source phase request.
- `busy_o`, out, 1: run in progress.
- `done_o`, out, 1: one-cycle run-complete pulse.
- `error_o`, out, 1: sticky watchdog error.
- `step_cnt_o`, out, STEP_W: number of completed steps.
- `phase_o`, out, 2: current phase; 0 = idle/other, 1 = Hy, 2 = Ez, 3 = source.

## Operation
- States: IDLE, HY_ISSUE, HY_WAIT, EZ_ISSUE, EZ_WAIT, SRC_ISSUE, SRC_WAIT, STEP_CHK, DONE.
- All outputs are Moore outputs decoded from the registered state and registers.
  - `calc_Hy_flg_o` is high only in HY_ISSUE, `calc_Ez_flg_o` only in EZ_ISSUE, `calc_src_flg_o` only in SRC_ISSUE.
  - `done_o` is high only in DONE.
  - `busy_o` is high in every state except IDLE.
- IDLE, when `start_i` = 1:
  - latch `time_steps_i` and `src_en_i`;
  - clear `step_cnt` and `error_o`;
  - go to STEP_CHK. The step-count comparison therefore precedes the first phase.
- Each ISSUE state lasts exactly 1 cycle, then moves to its WAIT state.
- HY_WAIT goes to EZ_ISSUE on `hy_wb_done_i`.
- EZ_WAIT on `ez_wb_done_i`:
  - goes to SRC_ISSUE if the latched `src_en` is 1;
  - otherwise increments `step_cnt` and goes to STEP_CHK.
- SRC_WAIT on `src_wb_done_i`: increments `step_cnt` and goes to STEP_CHK.
- STEP_CHK: goes to DONE if `step_cnt` equals the latched steps, else to HY_ISSUE.
- DONE goes to IDLE.
- Watchdog:
  - the counter clears on entry to each WAIT state and increments every cycle in WAIT;
  - if it reaches WDOG_CYCLES without the expected done: set `error_o`, go to IDLE, no `done_o`.
- Boundary rules:
  - `time_steps_i` = 0 gives no phase flags, only `done_o`.
  - `start_i` outside IDLE is ignored.
  - A done input other than the one expected by the current WAIT state is ignored. This includes a done arriving in an ISSUE state.
  - `abort_i` in any non-IDLE state forces IDLE at the next edge. It takes priority over a simultaneous done or watchdog expiry: no `done_o`, no `error_o`, no `step_cnt` increment.
  - `step_cnt_o` holds its value after abort or error until the next accepted start.
  - A done and watchdog expiry in the same cycle: the done wins.
  - Reset mid-run: all state and outputs return to reset values immediately (asynchronous).
- Reset values: state IDLE; every output 0.

## Timing
- Let `start_i` be sampled high at edge N.
  - STEP_CHK occupies cycle N to N+1.
  - `calc_Hy_flg_o` is high for cycle N+1 to N+2.
- A done sampled at edge M moves the block to the next ISSUE state, so that phase's flag is high for cycle M to M+1. Phase-to-phase overhead is 1 cycle.
- Step boundary: the final done at edge M, then STEP_CHK at M, then `calc_Hy_flg_o` at M+1.
- Final step: `done_o` is high for cycle M+1 to M+2; `busy_o` falls at edge M+2.
- `time_steps_i` = 0: `done_o` is high for cycle N+1 to N+2.
- Watchdog expiry: `error_o` rises WDOG_CYCLES cycles after WAIT entry; `busy_o` falls at the same edge.

## Structure
- Shared package `fdtd_pkg` holds:
  - the state enum `sched_state_e`;
  - phase codes `PH_IDLE`/`PH_HY`/`PH_EZ`/`PH_SRC` (2-bit);
  - the default `WDOG_CYCLES`.
- One sub-module, `fdtd_wdog`: a clear/enable counter with an expiry flag, parameterised by WDOG_W and WDOG_CYCLES.

## Test plan
1. `time_steps_i` = 3, `src_en_i` = 1, each done returned 5 cycles after its flag → exactly 9 flag pulses in the order Hy, Ez, src ×3; one `done_o`; `step_cnt_o` = 3; `error_o` = 0.
2. `time_steps_i` = 0 → `done_o` is high for the cycle after start; no flags; `step_cnt_o` = 0.
3. `time_steps_i` = 2, `src_en_i` = 0 → flags Hy, Ez, Hy, Ez only; `calc_src_flg_o` is never high; `step_cnt_o` = 2.
4. WDOG_CYCLES = 8, `ez_wb_done_i` withheld in step 0 → `error_o` = 1 eight cycles after EZ_WAIT entry; `busy_o` = 0; no `done_o`; a new start clears `error_o`.
5. `abort_i` in EZ_WAIT of step 1, with `ez_wb_done_i` in the same cycle → IDLE next cycle; `step_cnt_o` holds 1; no `done_o` and no further flags; the late done is ignored.
6. `start_i` pulsed in HY_WAIT and a spurious `hy_wb_done_i` in EZ_WAIT → both ignored; then `RST_N` low mid-run → all outputs 0 immediately.
